// File: rtl/test_result_monitor.sv
// Passive 6502 bus snooper: captures a result byte and a write checksum,
// detects end-of-test by halt write, parked fetch loop or cycle timeout.
//
// state  | meaning
// S_IDLE | waiting for the first opcode fetch
// S_RUN  | test program running, bus activity tracked
// S_DONE | verdict latched, outputs frozen until reset
module test_result_monitor #(
  parameter logic [15:0] WATCH_ADDR  = 16'h0030,
  parameter logic [7:0]  EXPECT_DATA = 8'h9D,
  parameter logic [15:0] HALT_ADDR   = 16'hFFF0,
  parameter int          LOOP_LIMIT  = 8,
  parameter logic [15:0] MAX_CYCLES  = 16'd4000
) (
  input  logic        ph2,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  input  logic        sync,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [1:0]  stop_cause,
  output logic [7:0]  result,
  output logic        result_valid,
  output logic [7:0]  halt_code,
  output logic [7:0]  write_count,
  output logic [7:0]  checksum
);

  localparam int LW = $clog2(LOOP_LIMIT + 1);
  localparam logic [LW-1:0] LOOP_MAX = LW'(LOOP_LIMIT);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_HALT    = 2'b01;
  localparam logic [1:0] CAUSE_LOOP    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;
  logic [1:0]    stop_cause_q, stop_cause_d;
  logic [7:0]    result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic [7:0]    halt_code_q, halt_code_d;
  logic [7:0]    write_count_q, write_count_d;
  logic [7:0]    checksum_q, checksum_d;
  logic [15:0]   last_fetch_q, last_fetch_d;
  logic [LW-1:0] loop_cnt_q, loop_cnt_d;
  logic [15:0]   cycle_cnt_q, cycle_cnt_d;

  logic          active;
  logic          halt_hit;
  logic          loop_hit;
  logic          tmo_hit;
  logic [1:0]    cause;

  always_comb begin
    state_d        = state_q;
    done_d         = done_q;
    pass_d         = pass_q;
    timeout_d      = timeout_q;
    stop_cause_d   = stop_cause_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    halt_code_d    = halt_code_q;
    write_count_d  = write_count_q;
    checksum_d     = checksum_q;
    last_fetch_d   = last_fetch_q;
    loop_cnt_d     = loop_cnt_q;
    cycle_cnt_d    = cycle_cnt_q;
    halt_hit       = 1'b0;
    loop_hit       = 1'b0;
    tmo_hit        = 1'b0;
    cause          = CAUSE_NONE;

    // The fetch that leaves IDLE is itself the first RUN cycle.
    active = (state_q == S_RUN) || ((state_q == S_IDLE) && sync);

    if (active) begin
      state_d     = S_RUN;
      cycle_cnt_d = cycle_cnt_q + 16'd1;

      if (we) begin
        write_count_d = (write_count_q == 8'hFF) ? write_count_q : write_count_q + 8'd1;
        checksum_d    = checksum_q + wdata;
        if (addr == WATCH_ADDR) begin
          result_d       = wdata;
          result_valid_d = 1'b1;
        end
        if (addr == HALT_ADDR) begin
          halt_code_d = wdata;
          halt_hit    = 1'b1;
        end
      end

      if (sync) begin
        if (addr == last_fetch_q) begin
          loop_cnt_d = (loop_cnt_q == LOOP_MAX) ? loop_cnt_q : loop_cnt_q + 1'b1;
        end else begin
          loop_cnt_d   = LW'(1);
          last_fetch_d = addr;
        end
        loop_hit = (loop_cnt_d == LOOP_MAX);
      end

      tmo_hit = (cycle_cnt_q == MAX_CYCLES - 16'd1);

      if (halt_hit)      cause = CAUSE_HALT;
      else if (loop_hit) cause = CAUSE_LOOP;
      else if (tmo_hit)  cause = CAUSE_TIMEOUT;

      if (cause != CAUSE_NONE) begin
        state_d      = S_DONE;
        done_d       = 1'b1;
        stop_cause_d = cause;
        timeout_d    = (cause == CAUSE_TIMEOUT);
        // Verdict uses this cycle's capture so a same-edge watch write counts.
        pass_d       = result_valid_d && (result_d == EXPECT_DATA) &&
                       (cause != CAUSE_TIMEOUT);
      end
    end
  end

  always_ff @(posedge ph2) begin
    if (reset) begin
      state_q        <= S_IDLE;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      stop_cause_q   <= CAUSE_NONE;
      result_q       <= 8'h00;
      result_valid_q <= 1'b0;
      halt_code_q    <= 8'h00;
      write_count_q  <= 8'h00;
      checksum_q     <= 8'h00;
      last_fetch_q   <= 16'h0000;
      loop_cnt_q     <= '0;
      cycle_cnt_q    <= 16'h0000;
    end else begin
      state_q        <= state_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
      stop_cause_q   <= stop_cause_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      halt_code_q    <= halt_code_d;
      write_count_q  <= write_count_d;
      checksum_q     <= checksum_d;
      last_fetch_q   <= last_fetch_d;
      loop_cnt_q     <= loop_cnt_d;
      cycle_cnt_q    <= cycle_cnt_d;
    end
  end

  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign stop_cause   = stop_cause_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign halt_code    = halt_code_q;
  assign write_count  = write_count_q;
  assign checksum     = checksum_q;

endmodule

// File: doc/test_result_monitor.md
Name: test_result_monitor

Overview:
- Passive bus snooper on the 6502 core's memory bus. It consumes the writes a test program makes and reads them back as a verdict.
- Captures the byte written to a result address and a running write checksum.
- Detects end-of-test by any of: a halt-register write, a self-loop fetch, or a cycle timeout.
- Drives done/pass so regression benches and FPGA LEDs need no hierarchical RAM peeks.

Parameters:
- WATCH_ADDR, 16'h0030, address whose last written byte is the test result
- EXPECT_DATA, 8'h9D, value the result must equal for pass
- HALT_ADDR, 16'hFFF0, write here ends the test; written byte is latched as halt_code
- LOOP_LIMIT, 8, consecutive opcode fetches from one address that count as "parked"
- MAX_CYCLES, 16'd4000, clock edges in RUN before timeout

Ports:
- ph2  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- addr  in  16  CPU address bus
- wdata  in  8  CPU write data
- we  in  1  1 = bus write this cycle
- sync  in  1  1 = opcode fetch this cycle
- done  out  1  test finished; sticky until reset
- pass  out  1  verdict, valid when done
- timeout  out  1  finish was caused by MAX_CYCLES
- stop_cause  out  2  00 none, 01 halt write, 10 loop, 11 timeout
- result  out  8  last byte written to WATCH_ADDR
- result_valid  out  1  WATCH_ADDR written at least once
- halt_code  out  8  byte written to HALT_ADDR
- write_count  out  8  writes seen in RUN, saturating at 255
- checksum  out  8  sum mod 256 of all wdata written in RUN

Behaviour:
- Reset: state=IDLE. All outputs 0 (result, halt_code, checksum, write_count = 8'h00; stop_cause = 2'b00). Internal last_fetch = 16'h0000, loop_cnt = 0, cycle_cnt = 0. Reset asserted mid-RUN or in DONE clears everything on that edge.
- FSM:
  - IDLE -> RUN on the first edge with sync=1. That fetch is processed as a RUN cycle.
  - RUN -> DONE on a stop condition.
  - DONE is terminal until reset.
- Registered outputs: a bus cycle sampled at edge n is visible after edge n. No combinational path from inputs to outputs.
- In RUN, per edge:
  - we=1: write_count += 1, saturating at 255; checksum += wdata, mod 256, no saturation.
  - we=1 and addr==WATCH_ADDR: result <= wdata, result_valid <= 1. Repeated writes overwrite; the last one wins.
  - we=1 and addr==HALT_ADDR: halt_code <= wdata; halt stop condition.
  - sync=1 and addr==last_fetch: loop_cnt += 1, saturating.
  - sync=1 and addr!=last_fetch: loop_cnt <= 1 and last_fetch <= addr.
  - Loop stop condition: loop_cnt reaches LOOP_LIMIT, i.e. the LOOP_LIMIT-th identical consecutive fetch.
  - cycle_cnt += 1 every RUN edge. Timeout stop condition when cycle_cnt reaches MAX_CYCLES-1 on this edge, so the test finishes on the MAX_CYCLES-th RUN edge.
- Simultaneous stop conditions: priority halt > loop > timeout. stop_cause reflects the winner. timeout=1 only if timeout wins.
- A watch write in the same cycle as the stop is still captured and included in the verdict.
- On entering DONE: done <= 1, and pass <= result_valid && result==EXPECT_DATA && cause!=timeout.
- In DONE: all outputs frozen; bus activity ignored.
- Writes to addresses other than WATCH_ADDR/HALT_ADDR affect only write_count and checksum.
- WATCH_ADDR==HALT_ADDR is legal: one write updates both result and halt_code and stops the test.
- Writes seen in IDLE (before the first sync) are ignored.

Test Plan:
- Program writes 8'h9D to 0x0030, then parks in JMP * at 0xF010 -> done after 8th fetch of 0xF010; stop_cause=10, pass=1, result=9D, result_valid=1.
- Writes 8'h12 then 8'h9D to 0x0030, then 8'h00 to 0x0030, then writes 8'h55 to 0xFFF0 -> done the edge after the halt write; stop_cause=01, halt_code=55, result=00, pass=0, write_count=4, checksum=8'h04.
- No write to 0x0030, loop reached -> done=1, result_valid=0, pass=0.
- Distinct fetch address every cycle, no halt, MAX_CYCLES=100 -> done exactly at the 100th RUN edge; timeout=1, stop_cause=11, pass=0.
- Halt write and 8th loop fetch on the same edge, with 0x0030 also written 8'h9D that edge -> stop_cause=01, pass=1.
- 300 writes of 8'h01 -> write_count=FF, checksum=8'h2C. Then assert reset for one edge mid-RUN -> all outputs 0, state IDLE; activity without sync leaves outputs unchanged.
